// File: rtl/numeros_com_sinal_divisor.sv
// Iterative mixed-signedness restoring divider: 8-bit dividend, 4-bit divisor,
// signed or unsigned sources chosen by codigo, signed 8-bit quotient/remainder.
module numeros_com_sinal_divisor (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] entrada_signed_1,
  input  logic [7:0] entrada_unsigned_1,
  input  logic [3:0] entrada_signed_2,
  input  logic [3:0] entrada_unsigned_2,
  input  logic [1:0] codigo,
  output logic       busy,
  output logic       done,
  output logic [7:0] quociente,
  output logic [7:0] resto,
  output logic       overflow,
  output logic       div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t     r_state;
  logic [7:0] r_q;
  logic [3:0] r_acc;
  logic [3:0] r_dvs;
  logic [2:0] r_cnt;
  logic       r_neg_a;
  logic       r_neg_b;
  logic       r_zero;
  logic [7:0] r_a_low;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_quoc;
  logic [7:0] r_resto;
  logic       r_ovf;
  logic       r_dz;

  logic [8:0] w_a9;
  logic [4:0] w_b5;
  logic [7:0] w_a_mag;
  logic [3:0] w_b_mag;
  logic [4:0] w_trial;
  logic       w_ge;
  logic       w_q_neg;

  // Operand select and extension to the common signed width
  always_comb begin
    w_a9 = codigo[1] ^ codigo[0] ? {1'b0, entrada_unsigned_1}
                                 : {entrada_signed_1[7], entrada_signed_1};
    w_b5 = codigo[0] ? {1'b0, entrada_unsigned_2}
                     : {entrada_signed_2[3], entrada_signed_2};
    w_a_mag = w_a9[8] ? 8'(-w_a9) : w_a9[7:0];
    w_b_mag = w_b5[4] ? 4'(-w_b5) : w_b5[3:0];
  end

  assign w_trial = {r_acc, r_q[7]};
  assign w_ge    = w_trial >= {1'b0, r_dvs};
  assign w_q_neg = r_neg_a ^ r_neg_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_acc   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_zero  <= 1'b0;
      r_a_low <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quoc  <= '0;
      r_resto <= '0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_q     <= w_a_mag;
            r_acc   <= '0;
            r_dvs   <= w_b_mag;
            r_cnt   <= '0;
            r_neg_a <= w_a9[8];
            r_neg_b <= w_b5[4];
            r_zero  <= (w_b_mag == 4'd0);
            r_a_low <= w_a9[7:0];
            r_busy  <= 1'b1;
            r_state <= (w_b_mag == 4'd0) ? FIX : CALC;
          end
        end
        CALC: begin
          // One restoring step: quotient bits shift in where dividend bits leave
          r_acc <= w_ge ? 4'(w_trial - {1'b0, r_dvs}) : w_trial[3:0];
          r_q   <= {r_q[6:0], w_ge};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= FIX;
        end
        FIX: begin
          if (r_zero) begin
            r_quoc  <= 8'hFF;
            r_resto <= r_a_low;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b1;
          end else begin
            r_quoc  <= w_q_neg ? 8'(-r_q) : r_q;
            r_resto <= r_neg_a ? 8'(-{4'd0, r_acc}) : {4'd0, r_acc};
            r_ovf   <= w_q_neg ? (r_q > 8'd128) : r_q[7];
            r_dz    <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quociente = r_quoc;
  assign resto     = r_resto;
  assign overflow  = r_ovf;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_numeros_com_sinal_divisor.sv
// Directed self-checking bench for numeros_com_sinal_divisor.
module tb_numeros_com_sinal_divisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] entrada_signed_1;
  logic [7:0] entrada_unsigned_1;
  logic [3:0] entrada_signed_2;
  logic [3:0] entrada_unsigned_2;
  logic [1:0] codigo;
  logic       busy;
  logic       done;
  logic [7:0] quociente;
  logic [7:0] resto;
  logic       overflow;
  logic       div_zero;

  int n_chk  = 0;
  int n_pass = 0;

  numeros_com_sinal_divisor dut (
    .clk(clk), .rst(rst), .start(start),
    .entrada_signed_1(entrada_signed_1), .entrada_unsigned_1(entrada_unsigned_1),
    .entrada_signed_2(entrada_signed_2), .entrada_unsigned_2(entrada_unsigned_2),
    .codigo(codigo), .busy(busy), .done(done), .quociente(quociente),
    .resto(resto), .overflow(overflow), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic launch(input logic [1:0] c, input logic [7:0] s1, input logic [7:0] u1,
                        input logic [3:0] s2, input logic [3:0] u2);
    @(negedge clk);
    codigo = c;
    entrada_signed_1 = s1; entrada_unsigned_1 = u1;
    entrada_signed_2 = s2; entrada_unsigned_2 = u2;
    start = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    codigo = ~c;
    entrada_signed_1 = 8'h5A; entrada_unsigned_1 = 8'h03;
    entrada_signed_2 = 4'h3;  entrada_unsigned_2 = 4'h2;
  endtask

  // Edges after the start edge until done; pulse_mid injects an ignored start
  task automatic wait_done(input bit pulse_mid, output int lat, output bit overlap);
    lat = 1;
    overlap = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (busy && done) overlap = 1'b1;
      if (done || lat >= 30) break;
      if (pulse_mid && lat == 3) start = 1'b1;
      if (pulse_mid && lat == 4) start = 1'b0;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] c, input logic [7:0] s1,
                     input logic [7:0] u1, input logic [3:0] s2, input logic [3:0] u2,
                     input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                     input logic eo, input logic ez, input bit pulse_mid);
    int  lat;
    bit  ov;
    launch(c, s1, u1, s2, u2);
    wait_done(pulse_mid, lat, ov);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_done_overlap"}, 32'(ov), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_quociente"}, 32'(quociente), 32'(eq));
    chk({tag, "_resto"}, 32'(resto), 32'(er));
    chk({tag, "_overflow"}, 32'(overflow), 32'(eo));
    chk({tag, "_div_zero"}, 32'(div_zero), 32'(ez));
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; codigo = 2'b00;
    entrada_signed_1 = '0; entrada_unsigned_1 = '0;
    entrada_signed_2 = '0; entrada_unsigned_2 = '0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_q", 32'(quociente), 32'd0);
    chk("reset_r", 32'(resto), 32'd0);
    chk("reset_flags", 32'({overflow, div_zero}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run("ss_m100_7",    2'b00, 8'h9C, 8'h00, 4'h7, 4'h0, 9, 8'hF2, 8'hFE, 1'b0, 1'b0, 1'b0);
    run("uu_255_15",    2'b01, 8'h00, 8'hFF, 4'h0, 4'hF, 9, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0);
    run("uu_255_1",     2'b01, 8'h00, 8'hFF, 4'h0, 4'h1, 9, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    run("us_201_m8",    2'b10, 8'h00, 8'hC9, 4'h8, 4'h0, 9, 8'hE7, 8'h01, 1'b0, 1'b0, 1'b0);
    run("su_m128_15",   2'b11, 8'h80, 8'h00, 4'h0, 4'hF, 9, 8'hF8, 8'hF8, 1'b0, 1'b0, 1'b0);
    run("ss_m128_m1",   2'b00, 8'h80, 8'h00, 4'hF, 4'h0, 9, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
    run("ss_m7_m2",     2'b00, 8'hF9, 8'h00, 4'hE, 4'h0, 9, 8'h03, 8'hFF, 1'b0, 1'b0, 1'b0);
    run("uu_77_0",      2'b01, 8'h00, 8'h4D, 4'h0, 4'h0, 1, 8'hFF, 8'h4D, 1'b0, 1'b1, 1'b0);
    run("ss_m5_0",      2'b00, 8'hFB, 8'h00, 4'h0, 4'h0, 1, 8'hFF, 8'hFB, 1'b0, 1'b1, 1'b0);

    run("start_in_calc", 2'b01, 8'h00, 8'h64, 4'h0, 4'h7, 9, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b1);
    no_done_for("no_extra_done", 14);

    launch(2'b00, 8'h9C, 8'h00, 4'h7, 4'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_q", 32'(quociente), 32'd0);
    chk("midrst_r", 32'(resto), 32'd0);
    chk("midrst_flags", 32'({done, overflow, div_zero}), 32'd0);
    @(negedge clk) rst = 1'b0;
    no_done_for("midrst_no_done", 14);

    run("after_reset", 2'b10, 8'h00, 8'hC9, 4'h8, 4'h0, 9, 8'hE7, 8'h01, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
